// File: rtl/apb_i2c_host_if.sv
// APB3 register front-end for the I2C master core: control/address registers,
// an APB-fed TX FIFO feeding the core, and a core-fed RX FIFO drained over APB.
module apb_i2c_host_if #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        i2c_reset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [7:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic [6:0]  addr,
    output logic        rw,
    output logic        i2c_enable,
    output logic [7:0]  i2c_data_in,
    input  logic [7:0]  i2c_data_out,
    input  logic        i2c_ready,
    input  logic        fifo_tx_rd_en,
    input  logic        fifo_rx_wr_en
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic             ctrl_en, ctrl_rw;
    logic [6:0]       addr_q;
    logic [7:0]       data_in_q;
    logic             tx_rd_q, rx_wr_q;
    logic             tx_unf, rx_ovf;

    logic [7:0]       tx_mem [FIFO_DEPTH];
    logic [7:0]       rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
    logic [CNT_W-1:0] tx_count, rx_count;

    logic access, wr_acc, rd_acc;
    logic sel_ctrl, sel_addr, sel_tx, sel_rx, sel_stat, unmapped;
    logic tx_empty, tx_full, rx_empty, rx_full;
    logic tx_pop_edge, rx_push_edge;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic [31:0] status;
    logic unused_bits;

    assign unused_bits = &{1'b0, paddr[1:0], pwdata[31:8]};

    assign access   = psel & penable;
    assign wr_acc   = access & pwrite;
    assign rd_acc   = access & ~pwrite;
    assign sel_ctrl = (paddr[7:2] == 6'd0);
    assign sel_addr = (paddr[7:2] == 6'd1);
    assign sel_tx   = (paddr[7:2] == 6'd2);
    assign sel_rx   = (paddr[7:2] == 6'd3);
    assign sel_stat = (paddr[7:2] == 6'd4);
    assign unmapped = ~(sel_ctrl | sel_addr | sel_tx | sel_rx | sel_stat);

    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == FULL_CNT);
    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == FULL_CNT);

    // Core strobes are levels; only their rising edges move data.
    assign tx_pop_edge  = fifo_tx_rd_en & ~tx_rd_q;
    assign rx_push_edge = fifo_rx_wr_en & ~rx_wr_q;

    assign tx_push = wr_acc & sel_tx & ~tx_full;
    assign tx_pop  = tx_pop_edge & ~tx_empty;
    assign rx_push = rx_push_edge & ~rx_full;
    assign rx_pop  = rd_acc & sel_rx & ~rx_empty;

    assign pready      = 1'b1;
    assign addr        = addr_q;
    assign rw          = ctrl_rw;
    assign i2c_data_in = data_in_q;
    assign i2c_enable  = ctrl_en & (ctrl_rw ? ~rx_full : ~tx_empty);

    always_ff @(posedge clk) begin
        if (i2c_reset) begin
            ctrl_en   <= 1'b0;
            ctrl_rw   <= 1'b0;
            addr_q    <= '0;
            data_in_q <= '0;
            tx_rd_q   <= 1'b0;
            rx_wr_q   <= 1'b0;
            tx_unf    <= 1'b0;
            rx_ovf    <= 1'b0;
            tx_wptr   <= '0;
            tx_rptr   <= '0;
            rx_wptr   <= '0;
            rx_rptr   <= '0;
            tx_count  <= '0;
            rx_count  <= '0;
        end else begin
            tx_rd_q <= fifo_tx_rd_en;
            rx_wr_q <= fifo_rx_wr_en;
            if (wr_acc & sel_ctrl) begin
                ctrl_en <= pwdata[0];
                ctrl_rw <= pwdata[1];
            end
            if (wr_acc & sel_addr) addr_q <= pwdata[6:0];

            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop) begin
                tx_rptr   <= tx_rptr + 1'b1;
                data_in_q <= tx_mem[tx_rptr];
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase

            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase

            // A new error event outranks a same-cycle write-1-to-clear.
            if (tx_pop_edge & tx_empty)             tx_unf <= 1'b1;
            else if (wr_acc & sel_stat & pwdata[6]) tx_unf <= 1'b0;
            if (rx_push_edge & rx_full)             rx_ovf <= 1'b1;
            else if (wr_acc & sel_stat & pwdata[5]) rx_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr] <= pwdata[7:0];
        if (rx_push) rx_mem[rx_wptr] <= i2c_data_out;
    end

    always_comb begin
        status              = '0;
        status[0]           = tx_empty;
        status[1]           = tx_full;
        status[2]           = rx_empty;
        status[3]           = rx_full;
        status[4]           = i2c_ready;
        status[5]           = rx_ovf;
        status[6]           = tx_unf;
        status[8 +: CNT_W]  = tx_count;
        status[16 +: CNT_W] = rx_count;
    end

    always_comb begin
        prdata = '0;
        if (rd_acc) begin
            case (paddr[7:2])
                6'd0:    prdata[1:0] = {ctrl_rw, ctrl_en};
                6'd1:    prdata[6:0] = addr_q;
                6'd3:    if (!rx_empty) prdata[7:0] = rx_mem[rx_rptr];
                6'd4:    prdata = status;
                default: prdata = '0;
            endcase
        end
    end

    assign pslverr = access & (unmapped
                             | (pwrite & sel_tx & tx_full)
                             | (~pwrite & sel_rx & rx_empty));

endmodule

// File: tb/tb_apb_i2c_host_if.sv
// Bench for apb_i2c_host_if: directed scenarios then randomized APB/core traffic,
// scored against a queue-based model of the register and FIFO behaviour.
module tb_apb_i2c_host_if;
    logic        clk = 1'b0;
    logic        i2c_reset;
    logic        psel, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;
    logic [6:0]  addr;
    logic        rw, i2c_enable;
    logic [7:0]  i2c_data_in, i2c_data_out;
    logic        i2c_ready, fifo_tx_rd_en, fifo_rx_wr_en;

    always #5 clk = ~clk;

    apb_i2c_host_if #(.FIFO_DEPTH(8), .CNT_W(4)) dut (
        .clk(clk), .i2c_reset(i2c_reset),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .addr(addr), .rw(rw), .i2c_enable(i2c_enable),
        .i2c_data_in(i2c_data_in), .i2c_data_out(i2c_data_out),
        .i2c_ready(i2c_ready), .fifo_tx_rd_en(fifo_tx_rd_en),
        .fifo_rx_wr_en(fifo_rx_wr_en)
    );

    // Reference model
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic       m_en, m_rw, m_rx_ovf, m_tx_unf;
    logic [6:0] m_addr;
    logic [7:0] m_din;

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s        = '0;
        s[0]     = (tx_q.size() == 0);
        s[1]     = (tx_q.size() == 8);
        s[2]     = (rx_q.size() == 0);
        s[3]     = (rx_q.size() == 8);
        s[4]     = i2c_ready;
        s[5]     = m_rx_ovf;
        s[6]     = m_tx_unf;
        s[11:8]  = 4'(tx_q.size());
        s[19:16] = 4'(rx_q.size());
        return s;
    endfunction

    task automatic model_reset();
        tx_q.delete();
        rx_q.delete();
        m_en = 0; m_rw = 0; m_rx_ovf = 0; m_tx_unf = 0; m_addr = '0; m_din = '0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_core(input string tag);
        logic exp_en;
        exp_en = m_en & (m_rw ? (rx_q.size() != 8) : (tx_q.size() != 0));
        check({tag, "_din"},  32'(i2c_data_in), 32'(m_din));
        check({tag, "_en"},   32'(i2c_enable),  32'(exp_en));
        check({tag, "_addr"}, 32'(addr),        32'(m_addr));
        check({tag, "_rw"},   32'(rw),          32'(m_rw));
    endtask

    task automatic apb(input logic wr, input logic [7:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic err);
        @(posedge clk); #1;
        psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1;
        #1;
        rd = prdata; err = pslverr;
        @(posedge clk); #1;
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic apb_chk(input string tag, input logic wr, input logic [7:0] a,
                           input logic [31:0] d, output logic [31:0] rd, output logic err);
        logic [31:0] exp_rd;
        logic        exp_err;
        exp_rd = '0; exp_err = 0;
        case (a[7:2])
            6'd0: if (!wr) exp_rd = {30'b0, m_rw, m_en};
            6'd1: if (!wr) exp_rd = {25'b0, m_addr};
            6'd2: if (wr && tx_q.size() == 8) exp_err = 1;
            6'd3: if (!wr) begin
                      if (rx_q.size() == 0) exp_err = 1;
                      else exp_rd = {24'b0, rx_q[0]};
                  end
            6'd4: if (!wr) exp_rd = exp_status();
            default: exp_err = 1;
        endcase
        apb(wr, a, d, rd, err);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        if (!wr) check({tag, "_rdata"}, rd, exp_rd);
        case (a[7:2])
            6'd0: if (wr) begin m_en = d[0]; m_rw = d[1]; end
            6'd1: if (wr) m_addr = d[6:0];
            6'd2: if (wr && tx_q.size() < 8) tx_q.push_back(d[7:0]);
            6'd3: if (!wr && rx_q.size() > 0) void'(rx_q.pop_front());
            6'd4: if (wr) begin
                      if (d[5]) m_rx_ovf = 0;
                      if (d[6]) m_tx_unf = 0;
                  end
            default: ;
        endcase
        check_core(tag);
    endtask

    task automatic core_tx(input int hold);
        @(posedge clk); #1;
        fifo_tx_rd_en = 1;
        repeat (hold) @(posedge clk);
        #1 fifo_tx_rd_en = 0;
        @(posedge clk); #1;
        if (tx_q.size() > 0) m_din = tx_q.pop_front();
        else m_tx_unf = 1;
        check_core("core_tx");
    endtask

    task automatic core_rx(input logic [7:0] d, input int hold);
        @(posedge clk); #1;
        fifo_rx_wr_en = 1; i2c_data_out = d;
        repeat (hold) @(posedge clk);
        #1 fifo_rx_wr_en = 0;
        @(posedge clk); #1;
        if (rx_q.size() < 8) rx_q.push_back(d);
        else m_rx_ovf = 1;
        check_core("core_rx");
    endtask

    // APB TXDATA access and core pop rising edge land on the same clk edge.
    task automatic tx_push_pop_same(input string tag, input logic [7:0] d);
        logic err, full_before;
        full_before = (tx_q.size() == 8);
        @(posedge clk); #1;
        psel = 1; penable = 0; pwrite = 1; paddr = 8'h08; pwdata = {24'b0, d};
        @(posedge clk); #1;
        penable = 1; fifo_tx_rd_en = 1;
        #1 err = pslverr;
        @(posedge clk); #1;
        psel = 0; penable = 0; pwrite = 0; fifo_tx_rd_en = 0;
        @(posedge clk); #1;
        check({tag, "_err"}, 32'(err), 32'(full_before));
        if (tx_q.size() > 0) m_din = tx_q.pop_front();
        else m_tx_unf = 1;
        if (!full_before) tx_q.push_back(d);
        check_core(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        logic [7:0]  a;
        logic [7:0]  oldest;

        i2c_reset = 1; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
        i2c_data_out = '0; i2c_ready = 0; fifo_tx_rd_en = 0; fifo_rx_wr_en = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 i2c_reset = 0;

        // Reset state
        check_core("reset");
        apb_chk("rst_status", 0, 8'h10, '0, rd, err);
        check("rst_status_const", rd, 32'h0000_0005);
        apb_chk("rst_ctrl", 0, 8'h00, '0, rd, err);
        apb_chk("rst_addr", 0, 8'h04, '0, rd, err);

        // Basic write transaction
        apb_chk("w_addr", 1, 8'h04, 32'h50, rd, err);
        apb_chk("w_tx0", 1, 8'h08, 32'hA5, rd, err);
        apb_chk("w_tx1", 1, 8'h08, 32'h3C, rd, err);
        apb_chk("w_ctrl", 1, 8'h00, 32'h1, rd, err);
        check("en_on", 32'(i2c_enable), 32'h1);
        core_tx(1);
        check("din_a5", 32'(i2c_data_in), 32'hA5);
        core_tx(2);
        check("din_3c", 32'(i2c_data_in), 32'h3C);
        check("en_off", 32'(i2c_enable), 32'h0);

        // Long strobe pops exactly once
        apb_chk("lv_tx0", 1, 8'h08, 32'h11, rd, err);
        apb_chk("lv_tx1", 1, 8'h08, 32'h22, rd, err);
        core_tx(10);
        apb_chk("lv_status", 0, 8'h10, '0, rd, err);
        check("lv_txcnt", 32'(rd[11:8]), 32'h1);
        core_tx(1);

        // TX fill to overflow
        for (int i = 0; i < 9; i++) apb_chk("fill_tx", 1, 8'h08, 32'(8'h40 + i), rd, err);
        check("fill_9th_err", 32'(err), 32'h1);
        apb_chk("fill_status", 0, 8'h10, '0, rd, err);
        check("fill_txfull", 32'({rd[11:8], rd[1]}), 32'h11);

        // RX fill, overflow, drain, clear
        apb_chk("rd_ctrl", 1, 8'h00, 32'h3, rd, err);
        for (int i = 0; i < 9; i++) core_rx(8'(8'h10 + i), 1);
        check("rx_en_off", 32'(i2c_enable), 32'h0);
        apb_chk("rx_status", 0, 8'h10, '0, rd, err);
        check("rx_full_ovf", 32'({rd[5], rd[3]}), 32'h3);
        for (int i = 0; i < 8; i++) begin
            apb_chk("rx_read", 0, 8'h0C, '0, rd, err);
            check("rx_read_val", rd, 32'(8'h10 + i));
        end
        apb_chk("rx_read_empty", 0, 8'h0C, '0, rd, err);
        check("rx_empty_err", 32'(err), 32'h1);
        apb_chk("clr_ovf", 1, 8'h10, 32'h20, rd, err);
        apb_chk("clr_ovf_st", 0, 8'h10, '0, rd, err);
        check("ovf_cleared", 32'(rd[5]), 32'h0);

        // Simultaneous push/pop at count 3
        apb_chk("sim_ctrl", 1, 8'h00, 32'h1, rd, err);
        for (int i = 0; i < 5; i++) core_tx(1);
        oldest = tx_q[0];
        tx_push_pop_same("sim3", 8'h99);
        check("sim3_oldest", 32'(i2c_data_in), 32'(oldest));
        apb_chk("sim3_status", 0, 8'h10, '0, rd, err);
        check("sim3_cnt", 32'(rd[11:8]), 32'h3);

        // Underflow on empty, then simultaneous push/pop at count 0
        for (int i = 0; i < 3; i++) core_tx(1);
        core_tx(1);
        apb_chk("unf_status", 0, 8'h10, '0, rd, err);
        check("unf_set", 32'(rd[6]), 32'h1);
        apb_chk("unf_clr", 1, 8'h10, 32'h40, rd, err);
        tx_push_pop_same("sim0", 8'h77);
        apb_chk("sim0_status", 0, 8'h10, '0, rd, err);

        // Reset mid-transaction
        check("pre_rst_en", 32'(i2c_enable), 32'h1);
        @(posedge clk); #1 i2c_reset = 1;
        @(posedge clk); #1 i2c_reset = 0;
        model_reset();
        check_core("mid_rst");
        apb_chk("mid_rst_status", 0, 8'h10, '0, rd, err);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) i2c_ready = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0, 1: apb_chk("r_txw", 1, 8'h08 | 8'($urandom_range(0, 3)), $urandom, rd, err);
                2:    apb_chk("r_rxr", 0, 8'h0C | 8'($urandom_range(0, 3)), '0, rd, err);
                3:    core_tx($urandom_range(1, 4));
                4, 5: core_rx(8'($urandom), $urandom_range(1, 3));
                6:    apb_chk("r_st", 0, 8'h10, '0, rd, err);
                7:    apb_chk("r_ctrl", 1, 8'h00, $urandom, rd, err);
                8:    apb_chk("r_stw", 1, 8'h10, $urandom, rd, err);
                default: begin
                    case ($urandom_range(0, 5))
                        0: apb_chk("r_addrw", 1, 8'h04, $urandom, rd, err);
                        1: apb_chk("r_ctrlr", 0, 8'h00, '0, rd, err);
                        2: apb_chk("r_addrr", 0, 8'h04, '0, rd, err);
                        3: apb_chk("r_txr", 0, 8'h08, '0, rd, err);
                        4: apb_chk("r_rxw", 1, 8'h0C, $urandom, rd, err);
                        default: begin
                            a = 8'(8'h14 + 4 * $urandom_range(0, 58)) | 8'($urandom_range(0, 3));
                            apb_chk("r_unmap", 1'($urandom_range(0, 1)), a, $urandom, rd, err);
                        end
                    endcase
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
